// File: rtl/conv_window_scanner.sv
// conv_window_scanner: address/sequence controller for KxK sliding-window
// filtering. Walks every full window of an IMG_W x IMG_H image in raster
// order, emits K*K tap reads per window, waits RD_LAT cycles for the
// accumulator, then emits one output-pixel write.
module conv_window_scanner #(
  parameter int IMG_W  = 300,
  parameter int IMG_H  = 200,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int RD_LAT = 1,
  parameter int ROW_W  = 8,
  parameter int COL_W  = 9,
  localparam int TAP_W = (K > 1) ? $clog2(K) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  output logic             rd_valid,
  output logic [ROW_W-1:0] rd_row,
  output logic [COL_W-1:0] rd_col,
  output logic [TAP_W-1:0] tap_row,
  output logic [TAP_W-1:0] tap_col,
  output logic             rd_first,
  output logic             rd_last,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_col,
  output logic             busy,
  output logic             done
);

  localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - K) / STRIDE + 1;
  localparam int LAT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t             state, state_n;
  logic [ROW_W-1:0]   out_row, out_row_n;
  logic [COL_W-1:0]   out_col, out_col_n;
  logic [TAP_W-1:0]   tr, tr_n;
  logic [TAP_W-1:0]   tc, tc_n;
  logic [LAT_W-1:0]   lat_cnt, lat_cnt_n;

  logic               tap_last;
  logic               win_last;

  // Next-state outputs, registered below so every output comes from a flop.
  logic               rd_valid_n, rd_first_n, rd_last_n, wr_en_n, busy_n, done_n;
  logic [ROW_W-1:0]   rd_row_n, wr_row_n;
  logic [COL_W-1:0]   rd_col_n, wr_col_n;
  logic [TAP_W-1:0]   tap_row_n, tap_col_n;

  // Next-state and counter update; everything holds while stalled.
  always_comb begin
    state_n   = state;
    out_row_n = out_row;
    out_col_n = out_col;
    tr_n      = tr;
    tc_n      = tc;
    lat_cnt_n = lat_cnt;
    tap_last  = (tr == TAP_W'(K - 1)) && (tc == TAP_W'(K - 1));
    win_last  = (out_row == ROW_W'(OUT_H - 1)) && (out_col == COL_W'(OUT_W - 1));
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n   = S_FETCH;
          out_row_n = '0;
          out_col_n = '0;
          tr_n      = '0;
          tc_n      = '0;
          lat_cnt_n = '0;
        end
      end
      S_FETCH: begin
        if (!stall) begin
          if (tap_last) begin
            if (RD_LAT == 0) begin
              state_n = S_WRITE;
            end else begin
              state_n   = S_DRAIN;
              lat_cnt_n = LAT_W'(RD_LAT);
            end
          end else if (tc == TAP_W'(K - 1)) begin
            tc_n = '0;
            tr_n = tr + TAP_W'(1);
          end else begin
            tc_n = tc + TAP_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!stall) begin
          if (lat_cnt == LAT_W'(1)) begin
            state_n = S_WRITE;
          end else begin
            lat_cnt_n = lat_cnt - LAT_W'(1);
          end
        end
      end
      S_WRITE: begin
        if (!stall) begin
          if (win_last) begin
            state_n   = S_DONE;
            out_row_n = '0;
            out_col_n = '0;
            tr_n      = '0;
            tc_n      = '0;
            lat_cnt_n = '0;
          end else begin
            state_n = S_FETCH;
            tr_n    = '0;
            tc_n    = '0;
            if (out_col == COL_W'(OUT_W - 1)) begin
              out_col_n = '0;
              out_row_n = out_row + ROW_W'(1);
            end else begin
              out_col_n = out_col + COL_W'(1);
            end
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output values implied by the next state, so the registered outputs
  // line up with the state they describe.
  always_comb begin
    rd_valid_n = (state_n == S_FETCH);
    wr_en_n    = (state_n == S_WRITE);
    busy_n     = (state_n == S_FETCH) || (state_n == S_DRAIN) || (state_n == S_WRITE);
    done_n     = (state_n == S_DONE);
    rd_row_n   = '0;
    rd_col_n   = '0;
    tap_row_n  = '0;
    tap_col_n  = '0;
    rd_first_n = 1'b0;
    rd_last_n  = 1'b0;
    wr_row_n   = '0;
    wr_col_n   = '0;
    if (state_n == S_FETCH) begin
      rd_row_n   = ROW_W'(32'(out_row_n) * STRIDE + 32'(tr_n));
      rd_col_n   = COL_W'(32'(out_col_n) * STRIDE + 32'(tc_n));
      tap_row_n  = tr_n;
      tap_col_n  = tc_n;
      rd_first_n = (tr_n == '0) && (tc_n == '0);
      rd_last_n  = (tr_n == TAP_W'(K - 1)) && (tc_n == TAP_W'(K - 1));
    end
    if (state_n == S_WRITE) begin
      wr_row_n = out_row_n;
      wr_col_n = out_col_n;
    end
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      out_row  <= '0;
      out_col  <= '0;
      tr       <= '0;
      tc       <= '0;
      lat_cnt  <= '0;
      rd_valid <= 1'b0;
      rd_row   <= '0;
      rd_col   <= '0;
      tap_row  <= '0;
      tap_col  <= '0;
      rd_first <= 1'b0;
      rd_last  <= 1'b0;
      wr_en    <= 1'b0;
      wr_row   <= '0;
      wr_col   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      out_row  <= out_row_n;
      out_col  <= out_col_n;
      tr       <= tr_n;
      tc       <= tc_n;
      lat_cnt  <= lat_cnt_n;
      rd_valid <= rd_valid_n;
      rd_row   <= rd_row_n;
      rd_col   <= rd_col_n;
      tap_row  <= tap_row_n;
      tap_col  <= tap_col_n;
      rd_first <= rd_first_n;
      rd_last  <= rd_last_n;
      wr_en    <= wr_en_n;
      wr_row   <= wr_row_n;
      wr_col   <= wr_col_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_conv_window_scanner.sv
// Testbench for conv_window_scanner: three small configurations, checked
// cycle by cycle against hand-computed window tables.
module tb_conv_window_scanner;

  logic clk = 1'b0;
  logic reset;
  logic start_v [3];
  logic stall_v [3];
  int   sel;

  always #5 clk = ~clk;

  // Config 0: 5x4, K=3, STRIDE=1, RD_LAT=1
  logic       a_rv, a_rf, a_rl, a_we, a_busy, a_done;
  logic [7:0] a_rr, a_wr;
  logic [8:0] a_rc, a_wc;
  logic [1:0] a_tr, a_tc;
  // Config 1: 5x4, K=3, STRIDE=2, RD_LAT=1
  logic       b_rv, b_rf, b_rl, b_we, b_busy, b_done;
  logic [7:0] b_rr, b_wr;
  logic [8:0] b_rc, b_wc;
  logic [1:0] b_tr, b_tc;
  // Config 2: 4x2, K=1, STRIDE=1, RD_LAT=0
  logic       c_rv, c_rf, c_rl, c_we, c_busy, c_done;
  logic [7:0] c_rr, c_wr;
  logic [8:0] c_rc, c_wc;
  logic [0:0] c_tr, c_tc;

  conv_window_scanner #(.IMG_W(5), .IMG_H(4), .K(3), .STRIDE(1), .RD_LAT(1), .ROW_W(8), .COL_W(9)) u0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .stall(stall_v[0]),
    .rd_valid(a_rv), .rd_row(a_rr), .rd_col(a_rc), .tap_row(a_tr), .tap_col(a_tc),
    .rd_first(a_rf), .rd_last(a_rl), .wr_en(a_we), .wr_row(a_wr), .wr_col(a_wc),
    .busy(a_busy), .done(a_done));

  conv_window_scanner #(.IMG_W(5), .IMG_H(4), .K(3), .STRIDE(2), .RD_LAT(1), .ROW_W(8), .COL_W(9)) u1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .stall(stall_v[1]),
    .rd_valid(b_rv), .rd_row(b_rr), .rd_col(b_rc), .tap_row(b_tr), .tap_col(b_tc),
    .rd_first(b_rf), .rd_last(b_rl), .wr_en(b_we), .wr_row(b_wr), .wr_col(b_wc),
    .busy(b_busy), .done(b_done));

  conv_window_scanner #(.IMG_W(4), .IMG_H(2), .K(1), .STRIDE(1), .RD_LAT(0), .ROW_W(8), .COL_W(9)) u2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .stall(stall_v[2]),
    .rd_valid(c_rv), .rd_row(c_rr), .rd_col(c_rc), .tap_row(c_tr), .tap_col(c_tc),
    .rd_first(c_rf), .rd_last(c_rl), .wr_en(c_we), .wr_row(c_wr), .wr_col(c_wc),
    .busy(c_busy), .done(c_done));

  // Observed outputs of the selected instance, packed in a fixed order.
  logic [43:0] obs;
  always_comb begin
    case (sel)
      0:       obs = {a_rv, a_rr, a_rc, a_tr, a_tc, a_rf, a_rl, a_we, a_wr, a_wc, a_busy, a_done};
      1:       obs = {b_rv, b_rr, b_rc, b_tr, b_tc, b_rf, b_rl, b_we, b_wr, b_wc, b_busy, b_done};
      default: obs = {c_rv, c_rr, c_rc, 1'b0, c_tr, 1'b0, c_tc, c_rf, c_rl, c_we, c_wr, c_wc, c_busy, c_done};
    endcase
  end

  typedef struct {
    int cfg;
    int wr_row;
    int wr_col;
    int row0;
    int col0;
  } vec_t;

  typedef struct {
    int k;
    int lat;
    int cycles;
  } cfg_t;

  localparam int NVEC = 16;
  vec_t vec [NVEC];
  cfg_t cfgs [3];

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [43:0] pack(input int v, input int rr, input int rc, input int tr,
                                       input int tc, input int f, input int l, input int we,
                                       input int wr, input int wc, input int b, input int d);
    return {1'(v), 8'(rr), 9'(rc), 2'(tr), 2'(tc), 1'(f), 1'(l), 1'(we), 8'(wr), 9'(wc), 1'(b), 1'(d)};
  endfunction

  task automatic check(input string name, input logic [43:0] got, input logic [43:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cfg %0d, t=%0t)", name, got, exp, sel, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cfg %0d)", name, got, exp, sel);
    end
  endtask

  // Advance one cycle; optionally stall 3 cycles first and confirm the freeze.
  task automatic step(input bit hold, input logic [43:0] exp, input string name, inout int cyc);
    if (hold) begin
      stall_v[sel] = 1'b1;
      repeat (3) begin
        @(negedge clk);
        cyc++;
        check(name, obs, exp);
      end
      stall_v[sel] = 1'b0;
    end
    @(negedge clk);
    cyc++;
    start_v[sel] = 1'b0;
  endtask

  // Start a full frame on one config and check every cycle until done.
  task automatic run_frame(input int cfg, input bit stall_en, input bit noise_en);
    int cyc;
    int kk;
    int lat;
    int n;
    logic [43:0] exp;
    sel = cfg;
    kk  = cfgs[cfg].k;
    lat = cfgs[cfg].lat;
    start_v[cfg] = 1'b1;
    @(negedge clk);
    start_v[cfg] = 1'b0;
    cyc = 0;
    n   = 0;
    for (int v = 0; v < NVEC; v++) begin
      if (vec[v].cfg != cfg) continue;
      for (int tr = 0; tr < kk; tr++) begin
        for (int tc = 0; tc < kk; tc++) begin
          exp = pack(1, vec[v].row0 + tr, vec[v].col0 + tc, tr, tc,
                     int'(tr == 0 && tc == 0), int'(tr == kk - 1 && tc == kk - 1),
                     0, 0, 0, 1, 0);
          check("fetch", obs, exp);
          if (noise_en && n == 1 && tr == 0 && tc == 0) start_v[cfg] = 1'b1;
          step(stall_en && n == 0 && tr == 1 && tc == 1, exp, "fetch_stall", cyc);
        end
      end
      for (int i = 0; i < lat; i++) begin
        exp = pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("drain", obs, exp);
        step(1'b0, exp, "drain", cyc);
      end
      exp = pack(0, 0, 0, 0, 0, 0, 0, 1, vec[v].wr_row, vec[v].wr_col, 1, 0);
      check("write", obs, exp);
      step(stall_en && n == 0, exp, "write_stall", cyc);
      n++;
    end
    exp = pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("done", obs, exp);
    check_int("frame_cycles", cyc, cfgs[cfg].cycles + (stall_en ? 6 : 0));
    @(negedge clk);
    check("done_level", obs, exp);
  endtask

  initial begin
    int cyc;
    // Hand-computed windows: output position and top-left image pixel.
    vec[0]  = '{0, 0, 0, 0, 0};
    vec[1]  = '{0, 0, 1, 0, 1};
    vec[2]  = '{0, 0, 2, 0, 2};
    vec[3]  = '{0, 1, 0, 1, 0};
    vec[4]  = '{0, 1, 1, 1, 1};
    vec[5]  = '{0, 1, 2, 1, 2};
    vec[6]  = '{1, 0, 0, 0, 0};
    vec[7]  = '{1, 0, 1, 0, 2};
    vec[8]  = '{2, 0, 0, 0, 0};
    vec[9]  = '{2, 0, 1, 0, 1};
    vec[10] = '{2, 0, 2, 0, 2};
    vec[11] = '{2, 0, 3, 0, 3};
    vec[12] = '{2, 1, 0, 1, 0};
    vec[13] = '{2, 1, 1, 1, 1};
    vec[14] = '{2, 1, 2, 1, 2};
    vec[15] = '{2, 1, 3, 1, 3};
    cfgs[0] = '{3, 1, 66};
    cfgs[1] = '{3, 1, 22};
    cfgs[2] = '{1, 0, 16};

    sel = 0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      stall_v[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      check("reset_state", obs, '0);
    end
    reset = 1'b0;
    @(negedge clk);

    run_frame(0, 1'b0, 1'b0);
    run_frame(0, 1'b0, 1'b1);
    run_frame(1, 1'b0, 1'b0);
    run_frame(2, 1'b0, 1'b0);
    run_frame(0, 1'b1, 1'b0);

    // Reset during the second window's drain cycle aborts the scan.
    sel = 0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    cyc = 0;
    repeat (20) begin
      @(negedge clk);
      cyc++;
    end
    check("pre_reset_drain", obs, pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    reset = 1'b1;
    @(negedge clk);
    check("reset_abort", obs, '0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_after_reset", obs, '0);
    end
    run_frame(0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
